// File: rtl/ts_stream_scheduler.sv
// ts_stream_scheduler: packet-granular round-robin scheduler over 4 TS stream FIFOs with null-packet fill
module ts_stream_scheduler #(
  parameter int PKT_LEN = 188,
  parameter int DIV     = 4
) (
  input  logic        clk2,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        null_ins_en,
  input  logic [3:0]  pkt_avail,
  input  logic [31:0] fifo_data,
  output logic [3:0]  rd_en,
  output logic [1:0]  mux_ctrl,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_sop,
  output logic        ts_eop,
  output logic        busy,
  output logic [15:0] null_cnt
);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(PKT_LEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_NULL = 2'd2;
  logic [CW-1:0] div_q;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    mux_q, mux_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [15:0]   null_q, null_d;
  logic [1:0]    grant;
  logic [7:0]    null_byte;
  logic          tick, last_byte;
  assign tick      = div_q == CW'(DIV - 1);
  assign last_byte = byte_cnt_q == BW'(PKT_LEN - 1);
  assign null_byte = byte_cnt_q == BW'(0) ? 8'h47 :
                     byte_cnt_q == BW'(1) ? 8'h1F :
                     byte_cnt_q == BW'(3) ? 8'h10 : 8'hFF;
  // Descending scan so the nearest requester after last_q wins; k=4 lands on last_q itself.
  always_comb begin
    grant = last_q;
    for (int k = 4; k >= 1; k--)
      if (pkt_avail[2'(last_q + 2'(k))]) grant = 2'(last_q + 2'(k));
  end
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    mux_d      = mux_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    null_d     = null_q;
    if (tick && state_q == S_IDLE) begin
      if (enable && |pkt_avail) begin
        mux_d      = grant;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end else if (enable && null_ins_en) begin
        byte_cnt_d = '0;
        state_d    = S_NULL;
      end
    end else if (tick && (state_q == S_SEND || state_q == S_NULL)) begin
      data_d     = state_q == S_SEND ? fifo_data[{mux_q, 3'b000} +: 8] : null_byte;
      valid_d    = 1'b1;
      sop_d      = byte_cnt_q == '0;
      eop_d      = last_byte;
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (last_byte) begin
        state_d = S_IDLE;
        last_d  = state_q == S_SEND ? mux_q : last_q;
        null_d  = state_q == S_NULL && null_q != 16'hFFFF ? null_q + 16'd1 : null_q;
      end
    end
  end
  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      div_q      <= '0;
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      last_q     <= 2'd3;
      mux_q      <= 2'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      null_q     <= 16'd0;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      mux_q      <= mux_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      null_q     <= null_d;
    end
  end
  // Gated by rst_n so a reset cycle that lands on a tick cannot pop a FIFO.
  assign rd_en    = rst_n && tick && state_q == S_SEND ? 4'b0001 << mux_q : 4'b0000;
  assign mux_ctrl = mux_q;
  assign ts_data  = data_q;
  assign ts_valid = valid_q;
  assign ts_sop   = sop_q;
  assign ts_eop   = eop_q;
  assign busy     = state_q != S_IDLE;
  assign null_cnt = null_q;
endmodule

// File: tb/tb_ts_stream_scheduler.sv
// tb_ts_stream_scheduler: directed table-driven bench for the TS stream scheduler
module tb_ts_stream_scheduler;
  localparam int PKT_LEN = 188;
  localparam int DIV     = 4;
  logic        clk2 = 1'b0;
  logic        rst_n, enable, null_ins_en;
  logic [3:0]  pkt_avail;
  logic [31:0] fifo_data;
  logic [3:0]  rd_en;
  logic [1:0]  mux_ctrl;
  logic [7:0]  ts_data;
  logic        ts_valid, ts_sop, ts_eop, busy;
  logic [15:0] null_cnt;
  int passes = 0, total = 0, cyc = 0;
  logic [7:0] pc [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  typedef struct {
    logic [3:0] avail;
    logic [1:0] grant;
  } vec_t;
  vec_t tbl [12];

  ts_stream_scheduler #(.PKT_LEN(PKT_LEN), .DIV(DIV)) dut (
    .clk2(clk2), .rst_n(rst_n), .enable(enable), .null_ins_en(null_ins_en),
    .pkt_avail(pkt_avail), .fifo_data(fifo_data), .rd_en(rd_en), .mux_ctrl(mux_ctrl),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_sop(ts_sop), .ts_eop(ts_eop),
    .busy(busy), .null_cnt(null_cnt)
  );

  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc <= cyc + 1;
  // Each FIFO head advances on a pop, giving every stream its own byte sequence.
  always @(posedge clk2)
    for (int i = 0; i < 4; i++) if (rd_en[i]) pc[i] <= pc[i] + 8'd1;
  always_comb
    for (int i = 0; i < 4; i++) fifo_data[8*i +: 8] = pc[i] * 8'd37 + 8'(i * 50);

  function automatic logic [7:0] nb(input int i);
    return i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 3 ? 8'h10 : 8'hFF;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic collect(input bit is_null, input logic [1:0] g, input string nm,
                         output int sop_t, output int eop_t);
    int n = 0, pops = 0, bad = 0, last_t = 0, gs = -1;
    logic prev_pop = 1'b0;
    logic [7:0] prev_byte = 8'd0, exp_b;
    sop_t = -1;
    eop_t = -1;
    for (int c = 0; c < PKT_LEN * DIV + 100; c++) begin
      @(negedge clk2);
      if (ts_valid) begin
        exp_b = is_null ? nb(n) : prev_byte;
        if (ts_data !== exp_b || ts_sop !== (n == 0) || ts_eop !== (n == PKT_LEN - 1) ||
            prev_pop !== !is_null || (n > 0 && cyc - last_t != DIV)) bad++;
        if (n == 0) sop_t = cyc;
        last_t = cyc;
        n++;
        if (ts_eop) begin
          eop_t = cyc;
          break;
        end
      end
      prev_pop = rd_en != 4'd0;
      if (rd_en != 4'd0) begin
        pops++;
        if (gs < 0) gs = int'(mux_ctrl);
        if (rd_en != (4'b0001 << g)) bad++;
        prev_byte = fifo_data[8*g +: 8];
      end
    end
    if (!is_null) check({nm, "_grant"}, gs, int'(g));
    check({nm, "_pops"}, pops, is_null ? 0 : PKT_LEN);
    check({nm, "_bytes"}, n, PKT_LEN);
    check({nm, "_byte_errs"}, bad, 0);
  endtask

  initial begin
    int s, e, prev_e, cnt;
    tbl[0]  = '{4'hF, 2'd0}; tbl[1]  = '{4'hF, 2'd1}; tbl[2]  = '{4'hF, 2'd2};
    tbl[3]  = '{4'hF, 2'd3}; tbl[4]  = '{4'hF, 2'd0}; tbl[5]  = '{4'h9, 2'd3};
    tbl[6]  = '{4'h9, 2'd0}; tbl[7]  = '{4'h4, 2'd2}; tbl[8]  = '{4'h4, 2'd2};
    tbl[9]  = '{4'h2, 2'd1}; tbl[10] = '{4'hA, 2'd3}; tbl[11] = '{4'hA, 2'd1};
    rst_n = 1'b0; enable = 1'b1; null_ins_en = 1'b0; pkt_avail = 4'hF;
    repeat (5) @(negedge clk2);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_valid", int'(ts_valid), 0);
    check("rst_mux", int'(mux_ctrl), 0);
    check("rst_null_cnt", int'(null_cnt), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    prev_e = 0;
    for (int i = 0; i < 12; i++) begin
      pkt_avail = tbl[i].avail;
      collect(1'b0, tbl[i].grant, $sformatf("rr%0d", i), s, e);
      if (i > 0) check($sformatf("rr%0d_gap", i), s - prev_e, 2 * DIV);
      prev_e = e;
    end
    pkt_avail = 4'h0; null_ins_en = 1'b1;
    fork begin repeat (100) @(negedge clk2); null_ins_en = 1'b0; end join_none
    collect(1'b1, 2'd0, "null", s, e);
    check("null_cnt_one", int'(null_cnt), 1);
    cnt = 0;
    repeat (40) begin @(negedge clk2); if (ts_valid) cnt++; end
    check("null_off_no_valid", cnt, 0);
    check("null_off_busy", int'(busy), 0);
    pkt_avail = 4'b0010;
    fork begin repeat (100) @(posedge ts_valid); enable = 1'b0; end join_none
    collect(1'b0, 2'd1, "en_drop", s, e);
    cnt = 0;
    repeat (60) begin @(negedge clk2); if (ts_valid && ts_sop) cnt++; end
    check("en_drop_no_sop", cnt, 0);
    check("en_drop_busy", int'(busy), 0);
    enable = 1'b1; pkt_avail = 4'b0100; cnt = 0;
    for (int c = 0; c < 1000 && cnt < 50; c++) begin
      @(negedge clk2);
      if (ts_valid) cnt++;
    end
    check("mid_rst_reach50", cnt, 50);
    rst_n = 1'b0;
    @(negedge clk2);
    check("mid_rst_valid", int'(ts_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_mux", int'(mux_ctrl), 0);
    check("mid_rst_null_cnt", int'(null_cnt), 0);
    check("mid_rst_rd_en", int'(rd_en), 0);
    rst_n = 1'b1; pkt_avail = 4'hF;
    collect(1'b0, 2'd0, "post_rst", s, e);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/ts_stream_scheduler.md
Name: ts_stream_scheduler

Overview:
- Packet-granular round-robin scheduler that shares the single TS output path among 4 stream FIFOs.
- Paces output bytes at one per DIV clocks, the same byte-slot rate as the FIFO read clock.
- Drives per-FIFO pops, mux_ctrl and framed byte output (sop/eop). Inserts MPEG-2 null packets when no stream is ready.
- Sits between the stream FIFOs (first-word-fall-through) and the TS output/QoS logic.

Parameters:
PKT_LEN, 188, bytes per TS packet (>=4)
DIV, 4, clocks per byte slot (>=2)

Ports:
clk2  in  1  system clock (100MHz)
rst_n  in  1  synchronous, active-low reset
enable  in  1  permits starting new packets
null_ins_en  in  1  permits null-packet insertion when idle
pkt_avail  in  4  bit i: FIFO i holds >=1 complete packet
fifo_data  in  32  FWFT head byte of FIFO i at bits [8i+7:8i]
rd_en  out  4  pop strobe, one-hot or zero (combinational)
mux_ctrl  out  2  index of currently/last granted stream
ts_data  out  8  output byte
ts_valid  out  1  ts_data valid, single-cycle pulse per byte
ts_sop  out  1  first byte of packet (qualified by ts_valid)
ts_eop  out  1  last byte of packet (qualified by ts_valid)
busy  out  1  state != IDLE
null_cnt  out  16  null packets emitted, saturating

Behaviour:
- Reset (rst_n=0 at clk2 edge):
  - Outputs: ts_data=0, ts_valid/sop/eop=0, mux_ctrl=0, null_cnt=0, busy=0, rd_en=0.
  - Internal: state=IDLE, tick counter=0, byte_cnt=0, last_grant=3 (first grant goes to 0).
  - Reset mid-packet aborts the packet immediately; no further pops occur.
- Tick:
  - Counter counts 0..DIV-1 and wraps, free-running after reset.
  - tick=1 in the cycle where counter==DIV-1.
  - All decisions and bytes occur only on tick cycles.
- FSM states: IDLE, SEND, NULL.
- IDLE on tick:
  - If enable and |pkt_avail: grant = first set bit of pkt_avail searching (last_grant+1) mod 4 upward, wrapping. mux_ctrl<=grant, byte_cnt<=0, go to SEND. No byte is emitted this tick.
  - Else if enable and null_ins_en: byte_cnt<=0, go to NULL. mux_ctrl is unchanged.
  - Else: stay in IDLE.
  - Not on a tick: stay in IDLE.
- SEND on tick:
  - rd_en[grant]=1 combinationally during that cycle.
  - Next edge: ts_data<=fifo_data[grant], ts_valid<=1, ts_sop<=(byte_cnt==0), ts_eop<=(byte_cnt==PKT_LEN-1), byte_cnt++.
  - On byte_cnt==PKT_LEN-1: last_grant<=grant, go to IDLE.
  - Output latency: 1 clock after the pop cycle.
- NULL on tick:
  - Same framing as SEND; rd_en stays 0.
  - Byte sequence: 0x47, 0x1F, 0xFF, 0x10, then 0xFF for the remaining PKT_LEN-4 bytes.
  - On the last byte: null_cnt++ (holds at 0xFFFF), go to IDLE.
- ts_valid/sop/eop are 1 for exactly one cycle per byte and 0 otherwise.
- Boundary conditions:
  - enable deasserted mid-packet: the current packet completes; no new packet starts.
  - pkt_avail changes mid-packet: ignored. The FIFO contract guarantees PKT_LEN bytes once pkt_avail was set.
  - null_ins_en changes mid-null-packet: the null packet completes.
  - Back-to-back packets: eop tick → IDLE; the next tick arbitrates. The gap is one slot.
  - Only one stream available: it is granted every packet, regardless of last_grant.
  - A stream never receives two consecutive grants while another requester is pending.
- Widths:
  - byte_cnt is wide enough for PKT_LEN-1 (8 bits at the default).
  - Grant search is modulo 4.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks while pkt_avail=4'hF → rd_en=0, ts_valid=0, mux_ctrl=0, null_cnt=0, busy=0. Release → first grant is stream 0.
- Single stream: pkt_avail=4'b0100, DIV=4 → mux_ctrl=2. Exactly 188 rd_en[2] pulses, 4 clocks apart. Exactly 188 ts_valid pulses, each 1 clock after its pop. ts_data matches the fifo_data[23:16] sequence. sop on byte 1, eop on byte 188, then busy=0.
- Round-robin: pkt_avail=4'hF held → grant order 0,1,2,3,0; each packet is 188 bytes. Then set pkt_avail=4'b1001 after stream 0 → next grant 3, then 0.
- Null insertion: pkt_avail=0, enable=1, null_ins_en=1 → bytes 47 1F FF 10 then 184×FF, rd_en never set, null_cnt=1. With null_ins_en=0 → no ts_valid.
- Enable drop: enable=0 at byte 100 of a stream-1 packet → bytes 101..188 are still emitted with eop. No further sop while enable=0.
- Mid-packet reset: rst_n=0 for 1 clock at byte 50 → all outputs at reset values next cycle. With pkt_avail=4'hF after release, the next packet is from stream 0 with sop set.
